// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the requester handshake and the FIFO write-port signals that
//   surround fifo_wr_arbiter.
//
//   Parameters
//     WIDTH    data width per beat (matches the FIFO WIDTH)
//     NUM_REQ  number of requesters
//
//   Signals (names are as seen from the arbiter)
//     i_req_stb      [NUM_REQ]        per-requester write request, held until acked
//     i_req_data     [NUM_REQ][WIDTH] requester k data at bits [k*WIDTH +: WIDTH]
//     o_req_ack      [NUM_REQ]        one-hot or zero, beat accepted this cycle
//     o_grant        [NUM_REQ]        registered one-hot owner, zero when idle
//     o_busy                          high while an owner is held
//     o_fifo_w_stb                    write strobe to the FIFO
//     o_fifo_w_data  [WIDTH]          owner's data to the FIFO, zero when idle
//     i_fifo_full                     FIFO full flag
//
//   Modports
//     master  environment side: requesters plus the FIFO full flag
//     slave   the arbiter itself
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]            i_req_stb;
  logic [NUM_REQ-1:0][WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            o_req_ack;
  logic [NUM_REQ-1:0]            o_grant;
  logic                          o_busy;
  logic                          o_fifo_w_stb;
  logic [WIDTH-1:0]              o_fifo_w_data;
  logic                          i_fifo_full;

  modport master (
    output i_req_stb, i_req_data, i_fifo_full,
    input  o_req_ack, o_grant, o_busy, o_fifo_w_stb, o_fifo_w_data
  );

  modport slave (
    input  i_req_stb, i_req_data, i_fifo_full,
    output o_req_ack, o_grant, o_busy, o_fifo_w_stb, o_fifo_w_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port between NUM_REQ
//   producers. One requester owns the port at a time; its beats are forwarded
//   while the FIFO is not full, and ownership rotates fairly starting from the
//   requester after the previous owner. Every change of owner costs one idle
//   arbitration cycle.
//
//   Parameters
//     WIDTH      data width per beat (matches the FIFO WIDTH)
//     NUM_REQ    number of requesters, >= 2
//     BURST_LEN  maximum beats per grant, >= 1 (burst build only)
//
//   Ports
//     clk      clock, rising edge
//     rst      asynchronous active-low reset
//     arb_bus  fifo_wr_arbiter_if.slave: requests/acks, grant/busy status,
//              FIFO write strobe/data and FIFO full
//
//   Build option
//     FIFO_ARB_BURST_EN  defined: a grant lasts up to BURST_LEN beats.
//                        undefined: the beat counter is absent and ownership
//                        is released after every accepted beat, so
//                        contending requesters interleave one beat each.
// -----------------------------------------------------------------------------

// Per-requester slice: ack qualification and data gating for one lane.
module fifo_wr_arbiter_lane #(
  parameter int WIDTH = 4
) (
  input  logic             i_grant,
  input  logic             i_stb,
  input  logic             i_full,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ack,
  output logic [WIDTH-1:0] o_data
);
  // Full gates the ack with no register in between, so a beat is never
  // offered to a full FIFO.
  assign o_ack  = i_grant & i_stb & ~i_full;
  assign o_data = i_data & {WIDTH{i_grant}};
endmodule

module fifo_wr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic           clk,
  input  logic           rst,
  fifo_wr_arbiter_if.slave arb_bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t                        r_state, w_state_nxt;
  logic [IDX_W-1:0]              r_owner, w_owner_nxt;
  logic [IDX_W-1:0]              r_last,  w_last_nxt;
  logic [NUM_REQ-1:0]            r_grant, w_grant_nxt;

  logic [NUM_REQ-1:0]            w_req_stb;
  logic [NUM_REQ-1:0][WIDTH-1:0] w_req_data;
  logic                          w_full;
  logic [NUM_REQ-1:0]            w_ack;
  logic [NUM_REQ-1:0][WIDTH-1:0] w_lane_data;
  logic [WIDTH-1:0]              w_wdata;

  logic [IDX_W-1:0]              w_pick;
  logic                          w_pick_vld;
  logic [IDX_W-1:0]              w_idx;
  logic                          w_accept;
  logic                          w_owner_stb;
  logic                          w_last_beat;
  logic                          w_release;

  assign w_req_stb  = arb_bus.i_req_stb;
  assign w_req_data = arb_bus.i_req_data;
  assign w_full     = arb_bus.i_fifo_full;

  // r_grant is the one-hot owner and is zero outside S_OWN, so it doubles as
  // the lane enable: nothing is acked or forwarded while idle.
  fifo_wr_arbiter_lane #(.WIDTH(WIDTH)) u_lane [NUM_REQ-1:0] (
    .i_grant (r_grant),
    .i_stb   (w_req_stb),
    .i_full  ({NUM_REQ{w_full}}),
    .i_data  (w_req_data),
    .o_ack   (w_ack),
    .o_data  (w_lane_data)
  );

  always_comb begin
    w_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) w_wdata |= w_lane_data[k];
  end

  assign w_accept    = |w_ack;
  assign w_owner_stb = w_req_stb[r_owner];

  // Round-robin search upward from last+1. The loop runs from the lowest
  // priority offset to the highest so the last hit is the winner.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_idx      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_idx = IDX_W'((int'(r_last) + i) % NUM_REQ);
      if (w_req_stb[w_idx]) begin
        w_pick     = w_idx;
        w_pick_vld = 1'b1;
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  assign w_last_beat = (r_cnt == CNT_W'(BURST_LEN - 1));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_state == S_IDLE)
      w_cnt_nxt = '0;
    else if (w_accept)
      w_cnt_nxt = r_cnt + 1'b1;
  end

  // Full blocks w_accept, so the count simply holds across full cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else      r_cnt <= w_cnt_nxt;
  end
`else
  // Every accepted beat ends the grant.
  assign w_last_beat = 1'b1;
`endif

  // Full never releases ownership: with full high there is no accept, and the
  // owner's strobe is still high.
  assign w_release = ~w_owner_stb | (w_accept & w_last_beat);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = S_OWN;
          w_owner_nxt = w_pick;
          w_grant_nxt = NUM_REQ'(1) << w_pick;
        end
      end
      S_OWN: begin
        if (w_release) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_owner;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // last resets to NUM_REQ-1 so requester 0 has first priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  assign arb_bus.o_req_ack     = w_ack;
  assign arb_bus.o_grant       = r_grant;
  assign arb_bus.o_busy        = (r_state == S_OWN);
  assign arb_bus.o_fifo_w_stb  = w_accept;
  assign arb_bus.o_fifo_w_data = w_wdata;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a table of first-grant vectors plus cycle traces
// of the multi-cycle scenarios. Each trace character is the expected ack for
// that cycle ('-' none, digit = requester). Requester beats are unique, and
// the data the FIFO must receive is queued when the trace is set up and popped
// on every write strobe.
module tb_fifo_wr_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fifo_wr_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus();

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .BURST_LEN(BL)) dut (
    .clk     (clk),
    .rst     (rst),
    .arb_bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] rq_data [N][16];
  int           rq_cnt  [N];
  int           rq_idx  [N];
  logic [W-1:0] exp_q [$];

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] grant;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < N; k++) begin
      if (rq_idx[k] < rq_cnt[k]) begin
        bus.i_req_stb[k]  = 1'b1;
        bus.i_req_data[k] = rq_data[k][rq_idx[k]];
      end else begin
        bus.i_req_stb[k]  = 1'b0;
        bus.i_req_data[k] = '0;
      end
    end
  endtask

  // Requester k gets n beats 0x{k}1, 0x{k}2, ...
  task automatic load(input int k, input int n);
    rq_cnt[k] = n;
    rq_idx[k] = 0;
    for (int j = 0; j < n; j++) rq_data[k][j] = W'((k << 4) | (j + 1));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.i_fifo_full = 1'b0;
    for (int k = 0; k < N; k++) begin
      rq_cnt[k] = 0;
      rq_idx[k] = 0;
    end
    drive_reqs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic run_trace(input string nm, input string tr, input string fl,
                           input logic [N-1:0] hold);
    int           pidx [N];
    int           k;
    byte          ch;
    logic [N-1:0] eack;
    logic [N-1:0] sack;
    logic         full_c;
    exp_q.delete();
    for (int j = 0; j < N; j++) pidx[j] = rq_idx[j];
    for (int c = 0; c < tr.len(); c++) begin
      ch = tr[c];
      if (ch >= 8'd48 && ch <= 8'd57) begin
        k = int'(ch) - 48;
        exp_q.push_back(rq_data[k][pidx[k]]);
        pidx[k]++;
      end
    end
    for (int c = 0; c < tr.len(); c++) begin
      full_c = (c < fl.len()) && (fl[c] == 8'd70);
      bus.i_fifo_full = full_c;
      @(negedge clk);
      ch   = tr[c];
      eack = '0;
      if (ch >= 8'd48 && ch <= 8'd57) eack[int'(ch) - 48] = 1'b1;
      chk($sformatf("%s c%0d ack", nm, c), bus.o_req_ack, eack);
      chk($sformatf("%s c%0d w_stb", nm, c), bus.o_fifo_w_stb, |eack);
      if (full_c && hold != '0)
        chk($sformatf("%s c%0d held grant", nm, c), bus.o_grant, hold);
      if (bus.o_fifo_w_stb) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL %s c%0d write: got data %0h, expected no write", nm, c, bus.o_fifo_w_data);
        end else begin
          chk($sformatf("%s c%0d w_data", nm, c), bus.o_fifo_w_data, exp_q.pop_front());
        end
      end else if (!full_c) begin
        chk($sformatf("%s c%0d idle w_data", nm, c), bus.o_fifo_w_data, '0);
      end
      sack = bus.o_req_ack;
      @(posedge clk);
      #1;
      for (int j = 0; j < N; j++) if (sack[j]) rq_idx[j]++;
      drive_reqs();
    end
    bus.i_fifo_full = 1'b0;
    chk({nm, " beats left unwritten"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    string t_s1, t_s2, t_s3, t_s4, t_s5a, t_s5b;
    int    o;
`ifdef FIFO_ARB_BURST_EN
    t_s1  = "-2222-22--";
    t_s2  = "-0000-1111-2222-3333-0000--";
    t_s3  = "-11---11-11--";
    t_s4  = "-00--33--";
    t_s5a = "-22";
    t_s5b = "-00--2222--";
`else
    t_s1  = "-2-2-2-2-2-2--";
    t_s2  = "-0-1-2-3-0-1-2-3-0-1-2-3-0-1-2-3-0-0-0-0--";
    t_s3  = "-1----1-1-1-1-1--";
    t_s4  = "-0-3-0-3--";
    t_s5a = "-2-";
    t_s5b = "-0-2-0-2-2-2-2--";
`endif

    tbl[0] = '{req: 4'b0001, grant: 4'b0001};
    tbl[1] = '{req: 4'b0110, grant: 4'b0010};
    tbl[2] = '{req: 4'b1000, grant: 4'b1000};
    tbl[3] = '{req: 4'b1111, grant: 4'b0001};
    tbl[4] = '{req: 4'b1100, grant: 4'b0100};
    tbl[5] = '{req: 4'b1010, grant: 4'b0010};

    bus.i_fifo_full = 1'b0;
    for (int k = 0; k < N; k++) begin
      rq_cnt[k] = 0;
      rq_idx[k] = 0;
    end
    drive_reqs();

    // Reset state, sampled while reset is held.
    #3;
    chk("reset grant", bus.o_grant, '0);
    chk("reset busy",  bus.o_busy, 1'b0);
    chk("reset ack",   bus.o_req_ack, '0);
    chk("reset w_stb", bus.o_fifo_w_stb, 1'b0);
    chk("reset w_data", bus.o_fifo_w_data, '0);

    // First grant out of reset, held by full so the owner can be inspected.
    foreach (tbl[i]) begin
      do_reset();
      for (int k = 0; k < N; k++) if (tbl[i].req[k]) load(k, 2);
      drive_reqs();
      bus.i_fifo_full = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d idle grant", i), bus.o_grant, '0);
      chk($sformatf("vec%0d idle busy", i), bus.o_busy, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      o = 0;
      for (int k = 0; k < N; k++) if (tbl[i].grant[k]) o = k;
      chk($sformatf("vec%0d grant", i), bus.o_grant, tbl[i].grant);
      chk($sformatf("vec%0d busy", i), bus.o_busy, 1'b1);
      chk($sformatf("vec%0d ack under full", i), bus.o_req_ack, '0);
      chk($sformatf("vec%0d w_stb under full", i), bus.o_fifo_w_stb, 1'b0);
      chk($sformatf("vec%0d owner data", i), bus.o_fifo_w_data, rq_data[o][0]);
      bus.i_fifo_full = 1'b0;
      #1;
      chk($sformatf("vec%0d ack", i), bus.o_req_ack, tbl[i].grant);
      chk($sformatf("vec%0d w_stb", i), bus.o_fifo_w_stb, 1'b1);
    end

    do_reset();
    load(2, 6);
    drive_reqs();
    run_trace("single", t_s1, "", '0);

    do_reset();
    load(0, 8);
    load(1, 4);
    load(2, 4);
    load(3, 4);
    drive_reqs();
    run_trace("contend", t_s2, "", '0);

    do_reset();
    load(1, 6);
    drive_reqs();
    run_trace("full", t_s3, "...FFF", 4'b0010);

    do_reset();
    load(0, 2);
    load(3, 2);
    drive_reqs();
    run_trace("drop", t_s4, "", '0);

    // Reset in the middle of a grant, then requester 0 must win first.
    do_reset();
    load(2, 6);
    drive_reqs();
    run_trace("rst_pre", t_s5a, "", '0);
    chk("rst mid ack before", bus.o_req_ack, 4'b0100);
    #2 rst = 1'b0;
    #1;
    chk("rst async ack",   bus.o_req_ack, '0);
    chk("rst async grant", bus.o_grant, '0);
    chk("rst async busy",  bus.o_busy, 1'b0);
    chk("rst async w_stb", bus.o_fifo_w_stb, 1'b0);
    chk("rst async w_data", bus.o_fifo_w_data, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    load(0, 2);
    drive_reqs();
    run_trace("rst_post", t_s5b, "", '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the write port of one `fifo` instance between NUM_REQ producers. Each producer presents a strobe/data pair and holds it until acknowledged; the arbiter selects one owner, forwards that owner's beats to the FIFO write port while the FIFO is not full, and rotates ownership fairly. It sits directly in front of the FIFO, between the producer blocks and `i_fifo_w_stb`/`i_fifo_w_data`/`o_fifo_full`.

## Interface
- WIDTH, 4: data width per beat; must match the FIFO WIDTH.
- NUM_REQ, 4: number of requesters, at least 2.
- BURST_LEN, 4: maximum beats accepted per grant, at least 1.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state immediately on assertion.
- i_req_stb  input  NUM_REQ  per-requester write request; held high with stable data until acked.
- i_req_data  input  NUM_REQ*WIDTH  requester k's data is bits [k*WIDTH +: WIDTH].
- o_req_ack  output  NUM_REQ  one-hot or zero; bit k high means requester k's beat is accepted this cycle.
- o_grant  output  NUM_REQ  one-hot registered owner; zero when idle.
- o_busy  output  1  high while in OWN.
- o_fifo_w_stb  output  1  to FIFO `i_fifo_w_stb`.
- o_fifo_w_data  output  WIDTH  to FIFO `i_fifo_w_data`; owner's data, zero when idle.
- i_fifo_full  input  1  from FIFO `o_fifo_full`.

## Operation
- State machine: IDLE, OWN.
- IDLE: if any `i_req_stb` is high, pick the first requester with a high strobe, searching upward from `last+1` and wrapping modulo NUM_REQ. Register it as owner, clear the beat counter, and go to OWN. Otherwise stay in IDLE.
- OWN, write rule: accept = `i_req_stb[owner] & ~i_fifo_full`.
  - `o_fifo_w_stb` equals accept.
  - `o_req_ack[owner]` equals accept.
  - `o_fifo_w_data` is the owner's data slice.
  - All other ack bits are 0.
- OWN, beat counter: increments on each accept. Its width is ceil(log2(BURST_LEN+1)).
- OWN, release to IDLE, with `last` <= owner and `o_grant` cleared, when either:
  - an accept occurs with counter == BURST_LEN-1, or
  - `i_req_stb[owner]` is low.
- FIFO full in OWN: no accept, counter unchanged, owner held. Ownership is never released because of full.
- The arbiter never asserts `o_fifo_w_stb` while `i_fifo_full` is high, so no beat is ever dropped.
- Simultaneous requests: only the round-robin winner is granted. The others keep their strobes high and are acked in later grants.
- Reset values:
  - state IDLE, owner 0, counter 0, `last` = NUM_REQ-1 (so requester 0 has first priority).
  - `o_grant`=0, `o_busy`=0, `o_req_ack`=0, `o_fifo_w_stb`=0, `o_fifo_w_data`=0.
- Reset mid-burst: state is cleared immediately. Beats acked before reset are already in the FIFO; unacked beats stay pending at the requester.

## Timing
- Request to first ack: 1 cycle. Cycle t is IDLE and arbitrates; ack can occur in cycle t+1.
- Acks and `o_fifo_w_stb` are combinational from the registered owner plus `i_req_stb`/`i_fifo_full`. The path from full to write strobe is zero-cycle.
- Within a grant, throughput is 1 beat/cycle. Each grant change costs exactly one IDLE bubble cycle.
- `o_grant`/`o_busy` are registered and change the cycle after the transition decision.

## Configuration
- `FIFO_ARB_BURST_EN` defined: grants last up to BURST_LEN beats, as described above.
- `FIFO_ARB_BURST_EN` undefined: the counter logic is removed and BURST_LEN is ignored. Release happens after every accepted beat, so contending requesters interleave strictly one beat each, with one bubble between beats.

## Test plan
- Single requester 2 strobes 6 beats (0x1..0x6), FIFO empty, burst enabled, BURST_LEN=4:
  - beats 0x1–0x4 are acked on consecutive cycles;
  - then one IDLE bubble;
  - then 0x5–0x6 are acked;
  - FIFO pops 1..6 in order.
- Requesters 0–3 all strobe continuously from reset: grant order is 0,1,2,3,0. Each grant carries 4 beats, with one bubble between grants.
- FIFO (DEPTH=4) fills mid-burst while full is held 3 cycles:
  - `o_fifo_w_stb` and acks stay 0 for those 3 cycles;
  - the owner is unchanged;
  - the burst resumes with the counter preserved;
  - no data is lost.
- Owner drops its strobe after 2 beats while requester 3 waits: the arbiter releases, idles 1 cycle, then grants 3.
- Assert `rst` low mid-burst:
  - all outputs go to 0 asynchronously;
  - after release, requester 0 (if requesting) is granted first.
- `FIFO_ARB_BURST_EN` undefined, requesters 1 and 2 both requesting: acks alternate 1,2,1,2 with one bubble between each.
